// File: rtl/bit_packer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : bit_packer_pkg                                              |
// | Purpose  : Shared constants and the FSM state type for bit_packer.     |
// |            Holds the default block/count widths, the 0xFF marker byte  |
// |            and the 0x00 stuff byte inserted after every marker.        |
// | Ports    : none (package)                                              |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package bit_packer_pkg;

   localparam int         c_blk_w  = 512;
   localparam int         c_cnt_w  = 9;
   localparam logic [7:0] c_marker = 8'hFF;
   localparam logic [7:0] c_stuff  = 8'h00;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      EMIT  = 3'd1,
      STUFF = 3'd2,
      FLUSH = 3'd3,
      FDONE = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/bit_packer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : bit_packer_if                                               |
// | Purpose  : Bundles the block input handshake, the flush request and    |
// |            the byte output handshake of bit_packer.                    |
// | Ports    : master - upstream encoder / byte sink side                  |
// |            slave  - bit_packer side                                    |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface bit_packer_if
   import bit_packer_pkg::*;
#(
   parameter int BLK_W = c_blk_w,
   parameter int CNT_W = c_cnt_w
);

   logic [BLK_W-1:0] data_in;
   logic [CNT_W-1:0] num_bits;
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic [7:0]       byte_out;
   logic             byte_valid;
   logic             byte_ready;
   logic             blk_done;
   logic             flush_done;

   modport master (
      output data_in, num_bits, in_valid, flush, byte_ready,
      input  in_ready, byte_out, byte_valid, blk_done, flush_done
   );

   modport slave (
      input  data_in, num_bits, in_valid, flush, byte_ready,
      output in_ready, byte_out, byte_valid, blk_done, flush_done
   );

endinterface
`default_nettype wire

// File: rtl/bit_packer_byte_stuffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : byte_stuffer                                                |
// | Purpose  : Selects the byte presented to the sink (packed data or the  |
// |            0x00 stuff byte) and flags a completed handshake of a 0xFF  |
// |            data byte so the FSM can insert the stuff byte next.        |
// | Ports    : i_data      packed data byte from the shift buffer          |
// |            i_stuff     1 while the stuff byte is being presented       |
// |            i_valid     byte is being presented                         |
// |            i_ready     sink accepts                                    |
// |            o_byte      byte driven to the sink                         |
// |            o_marker_hs handshake of a 0xFF data byte this cycle        |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module byte_stuffer
   import bit_packer_pkg::*;
(
   input  wire logic [7:0] i_data,
   input  wire logic       i_stuff,
   input  wire logic       i_valid,
   input  wire logic       i_ready,
   output logic      [7:0] o_byte,
   output logic            o_marker_hs
);

   assign o_byte      = i_stuff ? c_stuff : i_data;
   // The stuff byte itself is never a marker, so it cannot retrigger.
   assign o_marker_hs = i_valid && i_ready && !i_stuff && (i_data == c_marker);

endmodule
`default_nettype wire

// File: rtl/bit_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : bit_packer                                                  |
// | Purpose  : Packs variable-length, left-aligned Huffman-coded blocks    |
// |            into an MSB-first byte stream with 0x00 stuffing after each |
// |            0xFF. Leftover bits (<8) are carried into the next block;   |
// |            a flush pads them with 1s to a full byte.                   |
// | Ports    : clk    rising-edge clock                                    |
// |            reset  asynchronous active-high reset                       |
// |            bus    bit_packer_if.slave (block in, flush, byte out)      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module bit_packer
   import bit_packer_pkg::*;
#(
   parameter int BLK_W = c_blk_w,
   parameter int CNT_W = c_cnt_w
)(
   input wire logic   clk,
   input wire logic   reset,
   bit_packer_if.slave bus
);

   localparam logic [CNT_W:0] c_eight = (CNT_W+1)'(8);

   state_t             r_state;
   state_t             w_next;
   logic [BLK_W+7:0]   r_buf;          // left-aligned: residual bits, then block bits
   logic [CNT_W:0]     r_cnt;          // bits still held in r_buf during EMIT
   logic [2:0]         r_resid;        // residual bit count carried between blocks
   logic               r_flush_pending;
   logic               r_in_flush;     // steers STUFF back to FDONE instead of EMIT

   logic [7:0]         w_top8;
   logic [7:0]         w_low_mask;     // 1s below the residual bits
   logic [7:0]         w_resid_bits;
   logic [7:0]         w_pad_byte;
   logic [7:0]         w_raw_byte;
   logic [7:0]         w_byte;
   logic               w_valid;
   logic               w_hs;
   logic               w_marker_hs;
   logic               w_accept;
   logic               w_service;
   logic [BLK_W-1:0]   w_data_mask;
   logic [BLK_W-1:0]   w_data_m;
   logic [BLK_W+7:0]   w_load;
   logic [CNT_W:0]     w_total;
   logic               w_blk_done;
   logic               w_flush_done;

   assign w_top8       = r_buf[BLK_W+7 -: 8];
   assign w_low_mask   = 8'hFF >> r_resid;
   assign w_resid_bits = w_top8 & ~w_low_mask;
   assign w_pad_byte   = w_resid_bits | w_low_mask;
   assign w_raw_byte   = (r_state == FLUSH) ? w_pad_byte : w_top8;

   assign w_valid = ((r_state == EMIT) && (r_cnt >= c_eight)) ||
                    (r_state == STUFF) || (r_state == FLUSH);
   assign w_hs    = w_valid && bus.byte_ready;

   byte_stuffer u_stuffer (
      .i_data      (w_raw_byte),
      .i_stuff     (r_state == STUFF),
      .i_valid     (w_valid),
      .i_ready     (bus.byte_ready),
      .o_byte      (w_byte),
      .o_marker_hs (w_marker_hs)
   );

   assign w_accept  = (r_state == IDLE) && !r_flush_pending && bus.in_valid;
   assign w_service = (r_state == IDLE) && r_flush_pending;

   // Bits below the count are don't-care upstream; clear them so they can
   // never leak into the residual carried into the next block.
   assign w_data_mask = ~({BLK_W{1'b1}} >> bus.num_bits);
   assign w_data_m    = bus.data_in & w_data_mask;
   assign w_load      = {w_resid_bits, {BLK_W{1'b0}}} | ({w_data_m, 8'h00} >> r_resid);
   assign w_total     = {{(CNT_W-2){1'b0}}, r_resid} + {1'b0, bus.num_bits};

   always_comb begin
      w_next       = r_state;
      w_blk_done   = 1'b0;
      w_flush_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_flush_pending)
               w_next = (r_resid != 3'd0) ? FLUSH : FDONE;
            else if (bus.in_valid)
               w_next = EMIT;
         end
         EMIT: begin
            if (r_cnt < c_eight) begin
               w_blk_done = 1'b1;
               w_next     = IDLE;
            end else if (w_hs) begin
               w_next = w_marker_hs ? STUFF : EMIT;
            end
         end
         STUFF: begin
            if (w_hs)
               w_next = r_in_flush ? FDONE : EMIT;
         end
         FLUSH: begin
            if (w_hs)
               w_next = w_marker_hs ? STUFF : FDONE;
         end
         FDONE: begin
            w_flush_done = 1'b1;
            w_next       = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= IDLE;
         r_buf           <= '0;
         r_cnt           <= '0;
         r_resid         <= 3'd0;
         r_flush_pending <= 1'b0;
         r_in_flush      <= 1'b0;
      end else begin
         r_state         <= w_next;
         r_flush_pending <= bus.flush | (r_flush_pending & ~w_service);

         if (w_accept) begin
            r_buf <= w_load;
            r_cnt <= w_total;
         end

         if ((r_state == EMIT) && w_hs) begin
            r_buf <= r_buf << 8;
            r_cnt <= r_cnt - c_eight;
         end

         if ((r_state == EMIT) && (r_cnt < c_eight))
            r_resid <= r_cnt[2:0];

         if (w_service)
            r_in_flush <= 1'b1;
         else if (r_state == FDONE)
            r_in_flush <= 1'b0;

         if ((r_state == FLUSH) && w_hs) begin
            r_resid <= 3'd0;
            r_buf   <= '0;
         end
      end
   end

   assign bus.in_ready   = (r_state == IDLE) && !r_flush_pending;
   assign bus.byte_valid = w_valid;
   assign bus.byte_out   = w_valid ? w_byte : 8'h00;
   assign bus.blk_done   = w_blk_done;
   assign bus.flush_done = w_flush_done;

endmodule
`default_nettype wire

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 Parameter BLK_W, default 512, sets the width of one Huffman-coded block word.
REQ-002 Parameter CNT_W, default 9, sets the width of the valid-bit count.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  BLK_W  coded block; first bit at data_in[BLK_W-1], valid bits left-aligned, bits below the count ignored.
REQ-006 num_bits  input  CNT_W  count of valid bits in data_in, 0..511.
REQ-007 in_valid  input  1  data_in and num_bits valid; the upstream encoder drives it from its done output.
REQ-008 in_ready  output  1  block accepted on the edge where in_valid && in_ready.
REQ-009 flush  input  1  single-cycle request to byte-align and drain the residual bits (end of scan).
REQ-010 byte_out  output  8  packed stream byte, MSB first.
REQ-011 byte_valid  output  1  byte_out is valid.
REQ-012 byte_ready  input  1  sink accepts the byte on the edge where byte_valid && byte_ready.
REQ-013 blk_done  output  1  one-cycle pulse when every whole byte of an accepted block has been transferred.
REQ-014 flush_done  output  1  one-cycle pulse when a flush completes.

Function
REQ-015 States SHALL be IDLE, EMIT, STUFF, FLUSH, and FDONE.
REQ-016 in_ready SHALL be 1 only in IDLE with no flush pending.
REQ-017 On acceptance: append the num_bits valid bits after residual r (0..7); total t = r + num_bits; go to EMIT.
REQ-018 EMIT SHALL present the top 8 bits while at least 8 bits remain, and shift them out on each byte handshake.
REQ-019 After a handshake of byte 0xFF, the FSM SHALL enter STUFF, present 0x00 for one handshake, then return to EMIT.
REQ-020 When fewer than 8 bits remain, the FSM SHALL keep them as the new residual r = t mod 8, pulse blk_done for one cycle, and return to IDLE.
REQ-021 A block with num_bits = 0 SHALL emit no byte, leave r unchanged, and pulse blk_done the cycle after acceptance.
REQ-022 byte_out and byte_valid SHALL hold stable while byte_valid && !byte_ready; the FSM does not advance until the handshake.
REQ-023 A flush SHALL be latched into flush_pending in any state and serviced on the next entry to IDLE.
REQ-024 In the same cycle, an in_valid block SHALL take priority over a flush; the flush stays pending.
REQ-025 Flush with r > 0: pad to 8 bits with 1s, emit the byte, stuff 0x00 if the byte is 0xFF, then set r = 0.
REQ-026 After a flush, flush_done SHALL pulse for one cycle (state FDONE) and the FSM SHALL return to IDLE.
REQ-027 Flush with r = 0: emit no byte; flush_done pulses the cycle after servicing starts.
REQ-028 The bit counter SHALL be CNT_W+1 bits wide, so t up to 518 does not overflow.
REQ-029 The shift buffer SHALL be BLK_W+8 bits wide.
REQ-030 Throughput SHALL be one byte per cycle when byte_ready = 1; the first byte appears the cycle after acceptance.

Reset
REQ-031 Reset SHALL force state IDLE; r, the bit counter, and flush_pending to 0; and the shift buffer to 0.
REQ-032 Reset values: byte_out = 0x00, byte_valid = 0, in_ready = 1, blk_done = 0, flush_done = 0.
REQ-033 Reset asserted mid-block SHALL discard all buffered bits with no further bytes emitted; operation resumes in IDLE after release.

Structure
REQ-034 A shared package SHALL hold BLK_W, CNT_W, the state enumeration, the 0xFF marker constant, and the 0x00 stuff constant.
REQ-035 A single sub-module, byte_stuffer, SHALL be used: it detects 0xFF on handshake and inserts 0x00; the FSM and shift buffer stay in bit_packer.

Verification
REQ-036 Scenario: r = 0, num_bits = 16, data_in top bits 0xABCD, byte_ready = 1.
  Required response: bytes 0xAB then 0xCD on consecutive cycles, blk_done on the cycle after, r = 0.
REQ-037 Scenario: num_bits = 12 with top bits 0xFFF, then flush.
  Required response: byte 0xFF, stuff byte 0x00, then pad byte 0xFF, stuff byte 0x00, then flush_done.
REQ-038 Scenario: num_bits = 5 (0b10110), then num_bits = 3 (0b011).
  Required response: no byte for block 1; byte 0xB3 for block 2; two blk_done pulses.
REQ-039 Scenario: byte_ready held 0 for 4 cycles during EMIT.
  Required response: byte_out stable, no bytes lost or duplicated, order preserved.
REQ-040 Scenario: in_valid and flush in the same cycle with r = 3.
  Required response: block processed first, then the flush pads the new residual; flush_done follows blk_done.
REQ-041 Scenario: reset pulse in the middle of a 511-bit block.
  Required response: outputs return to their reset values at once; a following 8-bit block 0x5A emits exactly 0x5A.
